// File: rtl/polaris_pkg.sv
// Shared types and constants for the polaris_cpu OP-IMM sequencer.
// POLARIS_SHIFTS_EN adds SLLI/SRLI/SRAI to the legal decode and the ALU.
package polaris_pkg;

    typedef enum logic [2:0] {
        ST_RST,
        ST_FETCH,
        ST_EXEC0,
        ST_EXEC1,
        ST_EXEC2,
        ST_JAM
    } state_e;

    localparam logic [63:0] RESET_VECTOR_DEF = 64'hFFFF_FFFF_FFFF_FF00;

    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    localparam logic [2:0] F3_ADDI  = 3'b000;
    localparam logic [2:0] F3_SLLI  = 3'b001;
    localparam logic [2:0] F3_SLTI  = 3'b010;
    localparam logic [2:0] F3_SLTIU = 3'b011;
    localparam logic [2:0] F3_XORI  = 3'b100;
    localparam logic [2:0] F3_SRXI  = 3'b101;
    localparam logic [2:0] F3_ORI   = 3'b110;
    localparam logic [2:0] F3_ANDI  = 3'b111;

    localparam logic [1:0] SIZ_IDLE = 2'b00;
    localparam logic [1:0] SIZ_WORD = 2'b10;

    function automatic logic opimm_legal(logic [31:0] ir);
        logic ok;
        ok = 1'b0;
        if (ir[6:0] == OPC_OPIMM) begin
            case (ir[14:12])
                F3_ADDI, F3_SLTI, F3_SLTIU,
                F3_XORI, F3_ORI, F3_ANDI: ok = 1'b1;
`ifdef POLARIS_SHIFTS_EN
                F3_SLLI: ok = (ir[31:26] == 6'b000000);
                F3_SRXI: ok = (ir[31:26] == 6'b000000) ||
                              (ir[31:26] == 6'b010000);
`endif
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    function automatic logic [63:0] opimm_alu(logic [31:0] ir,
                                               logic [63:0] a);
        logic [63:0] imm;
        logic [63:0] r;
        imm = {{52{ir[31]}}, ir[31:20]};
        case (ir[14:12])
            F3_SLTI:  r = {63'd0, $signed(a) < $signed(imm)};
            F3_SLTIU: r = {63'd0, a < imm};
            F3_XORI:  r = a ^ imm;
            F3_ORI:   r = a | imm;
            F3_ANDI:  r = a & imm;
`ifdef POLARIS_SHIFTS_EN
            F3_SLLI:  r = a << ir[25:20];
            F3_SRXI:  r = ir[30] ? 64'($signed(a) >>> ir[25:20])
                                 : a >> ir[25:20];
`endif
            default:  r = a + imm;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/polaris_if.sv
// Instruction fetch bus between polaris_cpu (master) and memory (slave).
interface polaris_if;
    logic        iack_i;
    logic [31:0] idat_i;
    logic [63:0] iadr_o;
    logic [1:0]  isiz_o;

    modport master (input iack_i, input idat_i,
                    output iadr_o, output isiz_o);
    modport slave  (output iack_i, output idat_i,
                    input iadr_o, input isiz_o);
endinterface

// File: rtl/xrs.sv
// 32 x 64-bit integer register file, x0 hardwired to zero.
module xrs (
    input  logic        clk_i,
    input  logic [4:0]  raddr_i,
    output logic [63:0] rdata_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [63:0] wdata_i
);
    logic [63:0] regs_q [32];

    assign rdata_o = (raddr_i == 5'd0) ? 64'd0 : regs_q[raddr_i];

    // Contents survive reset; only the write strobe is gated by it.
    always_ff @(posedge clk_i) begin
        if (we_i && (waddr_i != 5'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end
endmodule

// File: rtl/polaris_cpu.sv
// Multi-cycle OP-IMM-only RV64 sequencer; jams on any other word.
// Build with POLARIS_SHIFTS_EN to accept SLLI/SRLI/SRAI.
module polaris_cpu
    import polaris_pkg::*;
#(
    parameter logic [63:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
    input  logic      clk_i,
    input  logic      reset_i,
    polaris_if.master ibus,
    output logic      jammed_o
);
    state_e      state_q;
    logic [63:0] pc_q;
    logic [31:0] ir_q;
    logic [63:0] rs1_q;
    logic [63:0] res_q;
    logic [63:0] iadr_q;
    logic [1:0]  isiz_q;
    logic        jam_q;
    logic [63:0] rdata;
    logic        we;

    assign we = (state_q == ST_EXEC2);

    xrs u_xrs (
        .clk_i   (clk_i),
        .raddr_i (ir_q[19:15]),
        .rdata_o (rdata),
        .we_i    (we),
        .waddr_i (ir_q[11:7]),
        .wdata_i (res_q)
    );

    assign ibus.iadr_o = iadr_q;
    assign ibus.isiz_o = isiz_q;
    assign jammed_o    = jam_q;

    // Bus outputs are registered: each transition loads the values
    // belonging to the state being entered.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ST_RST;
            pc_q    <= RESET_VECTOR;
            ir_q    <= '0;
            rs1_q   <= '0;
            res_q   <= '0;
            iadr_q  <= '0;
            isiz_q  <= SIZ_IDLE;
            jam_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_RST: begin
                    state_q <= ST_FETCH;
                    iadr_q  <= pc_q;
                    isiz_q  <= SIZ_WORD;
                end
                ST_FETCH: begin
                    if (ibus.iack_i) begin
                        ir_q    <= ibus.idat_i;
                        pc_q    <= pc_q + 64'd4;
                        state_q <= ST_EXEC0;
                        iadr_q  <= '0;
                        isiz_q  <= SIZ_IDLE;
                    end
                end
                ST_EXEC0: begin
                    rs1_q <= rdata;
                    if (opimm_legal(ir_q)) begin
                        state_q <= ST_EXEC1;
                    end else begin
                        state_q <= ST_JAM;
                        jam_q   <= 1'b1;
                    end
                end
                ST_EXEC1: begin
                    res_q   <= opimm_alu(ir_q, rs1_q);
                    state_q <= ST_EXEC2;
                end
                ST_EXEC2: begin
                    state_q <= ST_FETCH;
                    iadr_q  <= pc_q;
                    isiz_q  <= SIZ_WORD;
                end
                ST_JAM: begin
                    state_q <= ST_JAM;
                end
                default: begin
                    state_q <= ST_JAM;
                    jam_q   <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_polaris_cpu.sv
// Self-checking bench for polaris_cpu with a behavioural reference model.
module tb_polaris_cpu;
    localparam logic [63:0] RV = 64'hFFFF_FFFF_FFFF_FF00;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic jam;
    int checks = 0;
    int failures = 0;

    logic [63:0] mreg [32];
    logic [63:0] mpc;

    polaris_if bus ();

    polaris_cpu #(.RESET_VECTOR(RV)) dut (
        .clk_i    (clk),
        .reset_i  (rst_n),
        .ibus     (bus.master),
        .jammed_o (jam)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [63:0] ref_op(logic [31:0] w, logic [63:0] a);
        logic [63:0] imm;
        int sh;
        imm = {{52{w[31]}}, w[31:20]};
        sh = int'(w[25:20]);
        case (w[14:12])
            3'd0: return a + imm;
            3'd2: return ($signed(a) < $signed(imm)) ? 64'd1 : 64'd0;
            3'd3: return (a < imm) ? 64'd1 : 64'd0;
            3'd4: return a ^ imm;
            3'd6: return a | imm;
            3'd7: return a & imm;
            3'd1: return a << sh;
            default: begin
                if (w[30]) return 64'($signed(a) >>> sh);
                return a >> sh;
            end
        endcase
    endfunction

    function automatic logic [31:0] enc(logic [11:0] imm, int rs1,
                                        logic [2:0] f3, int rd);
        return {imm, 5'(rs1), f3, 5'(rd), 7'b0010011};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.iack_i = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        mpc = RV;
    endtask

    task automatic issue(input logic [31:0] w);
        bus.iack_i = 1'b1;
        bus.idat_i = w;
        step();
        bus.iack_i = 1'b0;
        bus.idat_i = $urandom;
        mpc = mpc + 64'd4;
    endtask

    task automatic run_op(input logic [31:0] w);
        logic [63:0] a;
        int rs1, rd;
        rs1 = int'(w[19:15]);
        rd = int'(w[11:7]);
        a = (rs1 == 0) ? 64'd0 : mreg[rs1];
        issue(w);
        if (rd != 0) mreg[rd] = ref_op(w, a);
        step();
        step();
        step();
    endtask

    task automatic test_reset();
        bus.iack_i = 1'b0;
        bus.idat_i = '0;
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (bus.iadr_o !== 64'd0 || bus.isiz_o !== 2'b00 || jam !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got adr=%h siz=%b jam=%b want 0/00/0",
                     bus.iadr_o, bus.isiz_o, jam);
        end
        rst_n = 1'b1;
        step();
        mpc = RV;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.iadr_o !== RV || bus.isiz_o !== 2'b10 || jam !== 1'b0) begin
                failures++;
                $display("FAIL bootstrap_fetch[%0d]: got adr=%h siz=%b jam=%b want %h/10/0",
                         i, bus.iadr_o, bus.isiz_o, jam, RV);
            end
            step();
        end
    endtask

    task automatic test_illegal();
        issue(32'h0000_0000);
        checks++;
        if (bus.isiz_o !== 2'b00 || jam !== 1'b0) begin
            failures++;
            $display("FAIL illegal_exec0: got siz=%b jam=%b want 00/0",
                     bus.isiz_o, jam);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (jam !== 1'b1 || bus.isiz_o !== 2'b00 || bus.iadr_o !== 64'd0) begin
                failures++;
                $display("FAIL illegal_jam[%0d]: got jam=%b siz=%b adr=%h want 1/00/0",
                         i, jam, bus.isiz_o, bus.iadr_o);
            end
        end
        bus.iack_i = 1'b1;
        bus.idat_i = 32'h0000_0013;
        step();
        checks++;
        if (jam !== 1'b1) begin
            failures++;
            $display("FAIL jam_ignores_ack: got jam=%b want 1", jam);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (jam !== 1'b0 || bus.iadr_o !== 64'd0) begin
            failures++;
            $display("FAIL jam_async_reset: got jam=%b adr=%h want 0/0",
                     jam, bus.iadr_o);
        end
        do_reset();
    endtask

    task automatic test_nop();
        issue(32'h0000_0013);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.isiz_o !== 2'b00 || bus.iadr_o !== 64'd0) begin
                failures++;
                $display("FAIL nop_idle[%0d]: got siz=%b adr=%h want 00/0",
                         i, bus.isiz_o, bus.iadr_o);
            end
            step();
        end
        checks++;
        if (bus.iadr_o !== 64'hFFFF_FFFF_FFFF_FF04 || bus.isiz_o !== 2'b10 ||
            jam !== 1'b0) begin
            failures++;
            $display("FAIL nop_next_fetch: got adr=%h siz=%b jam=%b want FF04/10/0",
                     bus.iadr_o, bus.isiz_o, jam);
        end
    endtask

    task automatic test_addi_chain();
        do_reset();
        run_op(32'hFFF0_0093);
        run_op(32'h0010_8113);
        checks++;
        if (dut.u_xrs.regs_q[1] !== 64'hFFFF_FFFF_FFFF_FFFF ||
            dut.u_xrs.regs_q[1] !== mreg[1]) begin
            failures++;
            $display("FAIL addi_x1: got %h want FFFFFFFFFFFFFFFF",
                     dut.u_xrs.regs_q[1]);
        end
        checks++;
        if (dut.u_xrs.regs_q[2] !== 64'd0 || dut.u_xrs.regs_q[2] !== mreg[2]) begin
            failures++;
            $display("FAIL addi_x2: got %h want 0", dut.u_xrs.regs_q[2]);
        end
        checks++;
        if (bus.iadr_o !== 64'hFFFF_FFFF_FFFF_FF08 || bus.iadr_o !== mpc) begin
            failures++;
            $display("FAIL addi_next_fetch: got %h want FFFFFFFFFFFFFF08",
                     bus.iadr_o);
        end
    endtask

    task automatic test_x0();
        run_op(32'h0050_0013);
        run_op(32'h0010_3193);
        checks++;
        if (dut.u_xrs.regs_q[3] !== 64'd1 || mreg[3] !== 64'd1) begin
            failures++;
            $display("FAIL x0_sltiu_x3: got %h want 1", dut.u_xrs.regs_q[3]);
        end
    endtask

    task automatic test_random();
        logic [2:0] f3tab [8];
        logic [31:0] w;
        logic [11:0] imm;
        logic [2:0] f3;
        int nf, rd, rs1;
        f3tab = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7, 3'd1, 3'd5};
`ifdef POLARIS_SHIFTS_EN
        nf = 8;
`else
        nf = 6;
`endif
        for (int r = 1; r < 32; r++) begin
            run_op(enc(12'($urandom), 0, 3'd0, r));
            checks++;
            if (dut.u_xrs.regs_q[r] !== mreg[r]) begin
                failures++;
                $display("FAIL rand_init_x%0d: got %h want %h",
                         r, dut.u_xrs.regs_q[r], mreg[r]);
            end
        end
        for (int n = 0; n < 80; n++) begin
            f3 = f3tab[$urandom_range(0, nf - 1)];
            imm = 12'($urandom);
            if (f3 == 3'd1) imm[11:6] = 6'b000000;
            if (f3 == 3'd5) imm[11:6] = ($urandom_range(0, 1) == 1) ? 6'b010000 : 6'b000000;
            rd = $urandom_range(0, 31);
            rs1 = $urandom_range(0, 31);
            w = enc(imm, rs1, f3, rd);
            run_op(w);
            checks++;
            if (rd != 0 && dut.u_xrs.regs_q[rd] !== mreg[rd]) begin
                failures++;
                $display("FAIL rand_op[%0d] w=%h x%0d: got %h want %h",
                         n, w, rd, dut.u_xrs.regs_q[rd], mreg[rd]);
            end
            checks++;
            if (bus.iadr_o !== mpc || bus.isiz_o !== 2'b10 || jam !== 1'b0) begin
                failures++;
                $display("FAIL rand_fetch[%0d]: got adr=%h siz=%b jam=%b want %h/10/0",
                         n, bus.iadr_o, bus.isiz_o, jam, mpc);
            end
        end
    endtask

    task automatic test_reset_mid_exec();
        logic [63:0] old;
        logic [11:0] imm;
        old = mreg[5];
        imm = (old == 64'h123) ? 12'h124 : 12'h123;
        issue(enc(imm, 0, 3'd0, 5));
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.iadr_o !== 64'd0 || jam !== 1'b0) begin
            failures++;
            $display("FAIL midexec_reset: got adr=%h jam=%b want 0/0",
                     bus.iadr_o, jam);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        mpc = RV;
        checks++;
        if (bus.iadr_o !== RV || bus.isiz_o !== 2'b10) begin
            failures++;
            $display("FAIL midexec_refetch: got adr=%h siz=%b want %h/10",
                     bus.iadr_o, bus.isiz_o, RV);
        end
        checks++;
        if (dut.u_xrs.regs_q[5] !== old) begin
            failures++;
            $display("FAIL midexec_x5_kept: got %h want %h",
                     dut.u_xrs.regs_q[5], old);
        end
    endtask

    task automatic test_random_illegal();
        logic [31:0] w;
        for (int n = 0; n < 10; n++) begin
            w = $urandom;
            if (n % 2 == 0) begin
                while (w[6:0] == 7'b0010011) w[6:0] = 7'($urandom);
            end else begin
                w[6:0] = 7'b0010011;
                w[14:12] = ($urandom_range(0, 1) == 1) ? 3'd1 : 3'd5;
`ifdef POLARIS_SHIFTS_EN
                w[31:26] = 6'b111111;
`endif
            end
            issue(w);
            checks++;
            if (jam !== 1'b0) begin
                failures++;
                $display("FAIL rand_illegal_exec0[%0d] w=%h: got jam=%b want 0",
                         n, w, jam);
            end
            step();
            step();
            checks++;
            if (jam !== 1'b1 || bus.isiz_o !== 2'b00) begin
                failures++;
                $display("FAIL rand_illegal_jam[%0d] w=%h: got jam=%b siz=%b want 1/00",
                         n, w, jam, bus.isiz_o);
            end
            do_reset();
        end
    endtask

    initial begin
        bus.iack_i = 1'b0;
        bus.idat_i = '0;
        for (int i = 0; i < 32; i++) mreg[i] = '0;
        test_reset();
        test_illegal();
        test_nop();
        test_addi_chain();
        test_x0();
        test_random();
        test_reset_mid_exec();
        test_random_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
